// File: rtl/des_pkg.sv
// Shared constants, types and rotation helpers for the DES key schedule controller.
package des_pkg;

  localparam int unsigned ROUNDS = 16;
  localparam int unsigned HALF_W = 28;
  localparam int unsigned CD_W   = 2 * HALF_W;
  localparam int unsigned SK_W   = 48;
  localparam int unsigned KEY_W  = 64;
  localparam int unsigned STEP_W = 4;

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(ROUNDS - 1);

  // Left-rotation amount applied to reach round n from round n-1.
  localparam logic [1:0] SHIFT_SCHED [1:16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  typedef enum logic {IDLE, RUN} state_t;

  // Cyclic rotation of one half; MSB is DES bit 0, so "left" moves toward the MSB.
  function automatic logic [HALF_W-1:0] rot_half(input logic [HALF_W-1:0] h,
                                                 input logic [1:0]        n,
                                                 input logic              right);
    logic [HALF_W-1:0] r;
    r = h;
    if (right) begin
      case (n)
        2'd1:    r = {h[0], h[HALF_W-1:1]};
        2'd2:    r = {h[1:0], h[HALF_W-1:2]};
        default: r = h;
      endcase
    end else begin
      case (n)
        2'd1:    r = {h[HALF_W-2:0], h[HALF_W-1]};
        2'd2:    r = {h[HALF_W-3:0], h[HALF_W-1:HALF_W-2]};
        default: r = h;
      endcase
    end
    return r;
  endfunction

  function automatic logic [CD_W-1:0] rot_cd(input logic [CD_W-1:0] cd,
                                             input logic [1:0]      n,
                                             input logic            right);
    return {rot_half(cd[CD_W-1:HALF_W], n, right), rot_half(cd[HALF_W-1:0], n, right)};
  endfunction

endpackage

// File: rtl/PermutedChoice1.sv
// DES PC-1: 64-bit key (bit 0 = MSB) to 56-bit C0D0, parity bits dropped.
module PermutedChoice1
  import des_pkg::*;
(
  input  logic [KEY_W-1:0] key,
  output logic [CD_W-1:0]  cd
);

  localparam int unsigned PC1_TAB [CD_W] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  for (genvar i = 0; i < CD_W; i++) begin : g_pc1
    assign cd[CD_W-1-i] = key[KEY_W-PC1_TAB[i]];
  end

endmodule

// File: rtl/PermutedChoice2.sv
// DES PC-2: 56-bit CnDn (bit 0 = MSB) to 48-bit round subkey.
module PermutedChoice2
  import des_pkg::*;
(
  input  logic [CD_W-1:0] cd,
  output logic [SK_W-1:0] sk
);

  localparam int unsigned PC2_TAB [SK_W] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  for (genvar i = 0; i < SK_W; i++) begin : g_pc2
    assign sk[SK_W-1-i] = cd[CD_W-PC2_TAB[i]];
  end

endmodule

// File: rtl/des_key_sched_ctrl.sv
// DES key schedule sequencer: accepts a key, streams 16 PC-2 subkeys in
// encrypt (K1..K16) or decrypt (K16..K1) order on a valid/ready interface.
module des_key_sched_ctrl
  import des_pkg::*;
#(
  parameter bit DECRYPT_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_valid,
  output logic              key_ready,
  input  logic [KEY_W-1:0]  key_in,
  input  logic              mode,
  input  logic              abort,
  output logic              sk_valid,
  input  logic              sk_ready,
  output logic [SK_W-1:0]   sk_data,
  output logic [STEP_W-1:0] sk_round,
  output logic              sk_last,
  output logic              busy
);

  state_t              state, state_next;
  logic [CD_W-1:0]     cd_reg, cd_next, cd_pc1;
  logic [STEP_W-1:0]   step, step_next;
  logic                dec, dec_next;
  logic [SK_W-1:0]     sk_pc2;
  logic [4:0]          sched_idx;

  PermutedChoice1 u_pc1 (.key(key_in), .cd(cd_pc1));
  PermutedChoice2 u_pc2 (.cd(cd_reg), .sk(sk_pc2));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cd_reg <= '0;
      step   <= '0;
      dec    <= 1'b0;
    end else begin
      state  <= state_next;
      cd_reg <= cd_next;
      step   <= step_next;
      dec    <= dec_next;
    end
  end

  always_comb begin
    state_next = state;
    cd_next    = cd_reg;
    step_next  = step;
    dec_next   = dec;
    sched_idx  = 5'd1;
    key_ready  = 1'b0;
    sk_valid   = 1'b0;
    sk_data    = '0;
    sk_round   = '0;
    sk_last    = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        key_ready = 1'b1;
        if (key_valid && !abort) begin
          dec_next   = DECRYPT_EN && mode;
          // Decrypt starts from C16D16, which equals C0D0.
          cd_next    = dec_next ? cd_pc1 : rot_cd(cd_pc1, SHIFT_SCHED[1], 1'b0);
          step_next  = '0;
          state_next = RUN;
        end
      end
      RUN: begin
        busy     = 1'b1;
        sk_valid = 1'b1;
        sk_data  = sk_pc2;
        sk_round = dec ? LAST_STEP - step : step;
        sk_last  = (step == LAST_STEP);
        if (abort) begin
          state_next = IDLE;
        end else if (sk_ready) begin
          if (step == LAST_STEP) begin
            state_next = IDLE;
          end else begin
            step_next = step + 4'd1;
            sched_idx = dec ? 5'd16 - 5'(step) : 5'(step) + 5'd2;
            cd_next   = rot_cd(cd_reg, SHIFT_SCHED[sched_idx], dec);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_des_key_sched_ctrl.sv
// Scoreboard bench for des_key_sched_ctrl using the classic 0x133457799BBCDFF1 key vectors.
module tb_des_key_sched_ctrl;

  typedef struct packed {
    logic [47:0] data;
    logic [3:0]  round;
    logic        last;
  } sk_t;

  localparam logic [63:0] KEY     = 64'h133457799BBCDFF1;
  localparam logic [55:0] PC1_VAL = 56'hF0CCAAF556678F;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_valid = 1'b0;
  logic        key_ready;
  logic [63:0] key_in = '0;
  logic        mode = 1'b0;
  logic        abort = 1'b0;
  logic        sk_valid;
  logic        sk_ready = 1'b0;
  logic [47:0] sk_data;
  logic [3:0]  sk_round;
  logic        sk_last;
  logic        busy;

  logic [47:0] ks [16] = '{
    48'b000110_110000_001011_101111_111111_000111_000001_110010,
    48'b011110_011010_111011_011001_110110_111100_100111_100101,
    48'b010101_011111_110010_001010_010000_101100_111110_011001,
    48'b011100_101010_110111_010110_110110_110011_010100_011101,
    48'b011111_001110_110000_000111_111010_110101_001110_101000,
    48'b011000_111010_010100_111110_010100_000111_101100_101111,
    48'b111011_001000_010010_110111_111101_100001_100010_111100,
    48'b111101_111000_101000_111010_110000_010011_101111_111011,
    48'b111000_001101_101111_101011_111011_011110_011110_000001,
    48'b101100_011111_001101_000111_101110_100100_011001_001111,
    48'b001000_010101_111111_010011_110111_101101_001110_000110,
    48'b011101_010111_000111_110101_100101_000110_011111_101001,
    48'b100101_111100_010111_010001_111110_101011_101001_000001,
    48'b010111_110100_001110_110111_111100_101110_011100_111010,
    48'b101111_111001_000110_001101_001111_010011_111100_001010,
    48'b110010_110011_110110_001011_000011_100001_011111_110101
  };

  int   tests = 0;
  int   fails = 0;
  sk_t  sb[$];

  des_key_sched_ctrl #(.DECRYPT_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_ready(key_ready),
    .key_in(key_in), .mode(mode), .abort(abort), .sk_valid(sk_valid),
    .sk_ready(sk_ready), .sk_data(sk_data), .sk_round(sk_round),
    .sk_last(sk_last), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_enc();
    for (int i = 0; i < 16; i++) sb.push_back(sk_t'{data: ks[i], round: 4'(i), last: (i == 15)});
  endtask

  task automatic push_dec();
    for (int i = 15; i >= 0; i--) sb.push_back(sk_t'{data: ks[i], round: 4'(i), last: (i == 0)});
  endtask

  task automatic push_zero();
    for (int i = 0; i < 16; i++) sb.push_back(sk_t'{data: 48'h0, round: 4'(i), last: (i == 15)});
  endtask

  // Monitor: handshake scoreboard plus stall stability.
  logic        prev_stall = 1'b0;
  logic [47:0] prev_data  = '0;
  logic [3:0]  prev_round = '0;
  always @(negedge clk) begin
    sk_t e;
    if (prev_stall) begin
      check("stall_valid", 64'(sk_valid), 64'd1);
      check("stall_data", 64'(sk_data), 64'(prev_data));
      check("stall_round", 64'(sk_round), 64'(prev_round));
    end
    prev_stall = rst_n && !abort && sk_valid && !sk_ready;
    prev_data  = sk_data;
    prev_round = sk_round;
    if (rst_n && !abort && sk_valid && sk_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_subkey: got %h round %0d, expected none", sk_data, sk_round);
      end else begin
        e = sb.pop_front();
        check("sk_data", 64'(sk_data), 64'(e.data));
        check("sk_round", 64'(sk_round), 64'(e.round));
        check("sk_last", 64'(sk_last), 64'(e.last));
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_key_ready"}, 64'(key_ready), 64'd1);
    check({tag, "_sk_valid"}, 64'(sk_valid), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_sk_data"}, 64'(sk_data), 64'd0);
    check({tag, "_sk_round"}, 64'(sk_round), 64'd0);
    check({tag, "_sk_last"}, 64'(sk_last), 64'd0);
  endtask

  task automatic send_key(input logic [63:0] k, input logic m);
    int n;
    n = 0;
    @(posedge clk); #1;
    key_in = k; mode = m; key_valid = 1'b1;
    @(negedge clk);
    while (!key_ready && n < 100) begin @(negedge clk); n++; end
    if (!key_ready) begin tests++; fails++; $display("FAIL key_accept_timeout: key_ready stayed 0"); end
    @(posedge clk); #1 key_valid = 1'b0;
    @(negedge clk);
    check("first_valid_latency", 64'(sk_valid), 64'd1);
  endtask

  task automatic wait_done(input bit rnd);
    int n;
    bit seen;
    n = 0;
    seen = sk_valid && sk_ready && sk_last;
    while (!seen && n < 400) begin
      @(posedge clk); #1;
      if (rnd) sk_ready = ($urandom_range(0, 9) >= 3);
      @(negedge clk);
      n++;
      if (sk_valid && sk_ready && sk_last) seen = 1'b1;
    end
    if (!seen) begin tests++; fails++; $display("FAIL last_timeout: sk_last handshake not seen"); end
    @(posedge clk); #1 sk_ready = 1'b1;
    @(negedge clk);
    check("key_ready_after_last", 64'(key_ready), 64'd1);
    check("busy_after_last", 64'(busy), 64'd0);
    check("sb_drained", 64'(sb.size()), 64'd0);
  endtask

  task automatic wait_round(input logic [3:0] r);
    int n;
    n = 0;
    while (!(sk_valid && sk_ready && sk_round == r) && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin tests++; fails++; $display("FAIL round_timeout: round %0d not reached", r); end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1 rst_n = 1'b1; sk_ready = 1'b1;

    // Encrypt order, free-running consumer
    push_enc();
    send_key(KEY, 1'b0);
    wait_done(1'b0);
    check("cd_restored_enc", 64'(dut.cd_reg), 64'(PC1_VAL));

    // Decrypt order
    push_dec();
    send_key(KEY, 1'b1);
    wait_done(1'b0);

    // Backpressure
    push_enc();
    send_key(KEY, 1'b0);
    wait_done(1'b1);
    check("cd_restored_bp", 64'(dut.cd_reg), 64'(PC1_VAL));

    // Abort after round 5 accepted
    push_enc();
    send_key(KEY, 1'b0);
    wait_round(4'd5);
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    check("abort_pending", 64'(sb.size()), 64'd10);
    sb.delete();
    @(negedge clk);
    check("abort_sk_valid", 64'(sk_valid), 64'd0);
    check("abort_key_ready", 64'(key_ready), 64'd1);
    check("abort_busy", 64'(busy), 64'd0);
    push_zero();
    send_key(64'h0, 1'b0);
    wait_done(1'b0);

    // Reset during a stalled round 9
    push_enc();
    send_key(KEY, 1'b0);
    wait_round(4'd8);
    @(posedge clk); #1 sk_ready = 1'b0;
    @(posedge clk); #1 rst_n = 1'b0; key_valid = 1'b1; key_in = 64'h0; mode = 1'b0;
    @(negedge clk);
    check("stalled_round", 64'(sk_round), 64'd9);
    @(posedge clk); #1;
    @(negedge clk);
    check_reset_outputs("midrun_reset");
    @(posedge clk); #1;
    @(negedge clk);
    check("reset_hold_busy", 64'(busy), 64'd0);
    check("reset_hold_key_ready", 64'(key_ready), 64'd1);
    sb.delete();
    push_zero();
    @(posedge clk); #1 rst_n = 1'b1; sk_ready = 1'b1;
    @(posedge clk); #1 key_valid = 1'b0;
    @(negedge clk);
    check("post_reset_accept_valid", 64'(sk_valid), 64'd1);
    check("post_reset_accept_busy", 64'(busy), 64'd1);
    wait_done(1'b0);

    // key_valid and abort together in IDLE
    @(posedge clk); #1 key_in = KEY; mode = 1'b0; key_valid = 1'b1; abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    push_enc();
    @(negedge clk);
    check("collision_busy", 64'(busy), 64'd0);
    check("collision_key_ready", 64'(key_ready), 64'd1);
    @(posedge clk); #1 key_valid = 1'b0;
    @(negedge clk);
    check("collision_k1_valid", 64'(sk_valid), 64'd1);
    check("collision_k1_round", 64'(sk_round), 64'd0);
    wait_done(1'b0);

    check("sb_final_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
